// File: rtl/counter_sched_rr.sv
// counter_sched_rr
//   Round-robin scheduler that time-shares one W-bit up-counter between
//   NREQ requesters. The winner's counter runs 0..len, then gets a one-cycle
//   done strobe. The pointer then advances past it.
//
// Ports
//   clk   : clock, rising edge
//   rst   : asynchronous, active-high reset
//   req   : [NREQ]   level request per requester
//   len   : [NREQ*W] terminal count per requester, slice i at [i*W +: W]
//   hold  : pauses counting while high (RUN only)
//   gnt   : [NREQ]   one-hot grant, zero when no owner
//   cnt   : [W]      shared counter value
//   busy  : high in RUN and DONE
//   done  : [NREQ]   one-cycle completion pulse to the finished requester
module counter_sched_rr #(
  parameter int NREQ = 4,
  parameter int W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] len,
  input  logic              hold,
  output logic [NREQ-1:0]   gnt,
  output logic [W-1:0]      cnt,
  output logic              busy,
  output logic [NREQ-1:0]   done
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [W-1:0]  tc;
  logic [PW-1:0] ptr;
  logic [PW-1:0] win;   // index of the current owner, used to advance ptr

  // First set req bit at or after ptr, wrapping back to index 0.
  logic [PW-1:0] pick;
  logic          found;
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        pick  = PW'((int'(ptr) + k) % NREQ);
      end
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      cnt   <= '0;
      tc    <= '0;
      ptr   <= '0;
      win   <= '0;
      done  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= '0;
          if (found) begin
            gnt   <= NREQ'(1) << pick;
            tc    <= len[int'(pick)*W +: W];
            cnt   <= '0;
            win   <= pick;
            state <= RUN;
          end
        end
        RUN: begin
          if (!hold) begin
            // Compare before increment so cnt never passes tc and never wraps.
            if (cnt == tc) begin
              done  <= gnt;
              gnt   <= '0;
              ptr   <= (win == PW'(NREQ-1)) ? '0 : win + 1'b1;
              state <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          // req is ignored here so the finished requester can drop it.
          done  <= '0;
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_sched_rr.sv
module tb_counter_sched_rr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [15:0] len = '0;
  logic        hold = 1'b0;
  logic [3:0]  gnt;
  logic [3:0]  cnt;
  logic        busy;
  logic [3:0]  done;

  counter_sched_rr #(.NREQ(4), .W(4)) dut (
    .clk(clk), .rst(rst), .req(req), .len(len), .hold(hold),
    .gnt(gnt), .cnt(cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_len(input int i, input logic [3:0] v);
    len[i*4 +: 4] = v;
  endtask

  function automatic int idx_of(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  int busy_n;
  int gidx[$];
  int gcyc[$];
  logic [3:0] pg;
  int dly;
  bit seen;

  initial begin
    // Reset state
    #12;
    chk("rst_gnt", gnt, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk); rst = 1'b0;
    tick;

    // Single requester, len0=3
    set_len(0, 3); req = 4'b0001;
    tick;
    chk("s_gnt0", gnt, 4'b0001);
    chk("s_busy", busy, 1);
    chk("s_cnt0", cnt, 0);
    req = 4'b0000;
    for (int k = 1; k <= 3; k++) begin
      tick;
      chk("s_cnt", cnt, k);
      chk("s_gnt", gnt, 4'b0001);
    end
    tick;
    chk("s_done", done, 4'b0001);
    chk("s_gnt_off", gnt, 0);
    tick;
    chk("s_done_off", done, 0);
    chk("s_idle", busy, 0);

    // len0=0: one RUN cycle at cnt=0 (ptr=1 wraps to 0)
    set_len(0, 0); req = 4'b0001;
    tick;
    chk("z_gnt", gnt, 4'b0001);
    chk("z_cnt", cnt, 0);
    req = 4'b0000;
    tick;
    chk("z_done", done, 4'b0001);
    tick;
    chk("z_idle", busy, 0);

    // len0=15: cnt 0..15, no wrap, busy for tc+2 = 17 cycles
    set_len(0, 15); req = 4'b0001;
    busy_n = 0;
    tick;
    req = 4'b0000;
    for (int k = 0; k <= 15; k++) begin
      if (busy) busy_n++;
      chk("m_cnt", cnt, k);
      chk("m_gnt", gnt, 4'b0001);
      tick;
    end
    if (busy) busy_n++;
    chk("m_done", done, 4'b0001);
    chk("m_cnt_nowrap", cnt, 15);
    tick;
    if (busy) busy_n++;
    chk("m_busy_cycles", busy_n, 17);
    chk("m_idle", busy, 0);

    // Reset mid-RUN at cnt=5
    set_len(0, 9); req = 4'b0001;
    tick;
    req = 4'b0000;
    repeat (5) tick;
    chk("r_cnt5", cnt, 5);
    #2 rst = 1'b1;
    #1;
    chk("r_gnt", gnt, 0);
    chk("r_cnt", cnt, 0);
    chk("r_busy", busy, 0);
    chk("r_done", done, 0);
    seen = 0;
    repeat (2) begin tick; if (done != 0) seen = 1; end
    chk("r_no_done", seen, 0);
    @(negedge clk); rst = 1'b0;

    // Fairness: all request, len=1 -> grants 0,1,2,3,0 spaced 4 apart
    for (int i = 0; i < 4; i++) set_len(i, 1);
    req = 4'b1111;
    pg = '0;
    for (int c = 0; c < 60 && gidx.size() < 5; c++) begin
      tick;
      chk("f_onehot", ($countones(gnt) <= 1), 1);
      chk("f_excl", gnt & done, 0);
      if (gnt != 0 && pg == 0) begin
        gidx.push_back(idx_of(gnt));
        gcyc.push_back(c);
      end
      pg = gnt;
    end
    req = 4'b0000;
    chk("f_ngrants", gidx.size(), 5);
    if (gidx.size() == 5) begin
      for (int i = 0; i < 5; i++) chk("f_order", gidx[i], i % 4);
      for (int i = 1; i < 5; i++) chk("f_spacing", gcyc[i] - gcyc[i-1], 4);
    end
    for (int c = 0; c < 20 && busy; c++) tick;
    chk("f_idle", busy, 0);

    // Hold for 3 cycles at cnt=2, len2 changed mid-run (ptr=1 -> req2 wins)
    set_len(2, 4); req = 4'b0100;
    tick;
    chk("h_gnt", gnt, 4'b0100);
    req = 4'b0000;
    tick; tick;
    chk("h_cnt2", cnt, 2);
    hold = 1'b1; set_len(2, 9);
    dly = 2;
    repeat (3) begin tick; dly++; chk("h_hold", cnt, 2); end
    hold = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick; dly++;
      if (done != 0) seen = 1;
      else chk("h_cnt_le4", (cnt <= 4), 1);
    end
    chk("h_done", done, 4'b0100);
    chk("h_cnt_final", cnt, 4);
    chk("h_delay", dly, 8);  // tc+1 with no hold, plus 3 hold cycles
    tick;

    // Withdrawal: req1 granted, drops during run; next goes to 3 (after 1)
    set_len(1, 2); set_len(3, 1); req = 4'b0010;
    tick;
    chk("w_gnt1", gnt, 4'b0010);
    req = 4'b1001;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin tick; if (done != 0) seen = 1; end
    chk("w_done", done, 4'b0010);
    tick;
    chk("w_idle", busy, 0);
    tick;
    chk("w_next", gnt, 4'b1000);
    req = 4'b0000;
    for (int c = 0; c < 20 && busy; c++) tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
